// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the core's data-RAM port.
// Serves loads/stores from a word RAM and a 16-byte MMIO window holding a
// cycle counter (CYCLE), an output FIFO push port (OUT_DATA), a status
// register (STATUS) and an overflow clear (CLEAR). The FIFO drains to an
// external valid/ready consumer.
// Optional feature macro: RAM_RESPONDER_CYCLE_CNT_EN. When defined the CYCLE
// counter register is built; when undefined no counter exists and CYCLE
// reads return 0.
module ram_responder #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 256,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] ram_address,
    input  logic [WIDTH-1:0] ram_w_data,
    input  logic             Read_Write_ram_en,
    output logic [WIDTH-1:0] ram_r_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Address decode: RAM occupies the low DEPTH words, MMIO a 4-word window.
    logic          w_ram_hit;
    logic          w_mmio_hit;
    logic [1:0]    w_off;
    logic [AW-1:0] w_ram_idx;
    logic          w_unused_byte_bits;

    assign w_ram_hit          = (ram_address[WIDTH-1:AW+2] == '0);
    assign w_mmio_hit         = (ram_address[WIDTH-1:4] == MMIO_BASE[WIDTH-1:4]);
    assign w_off              = ram_address[3:2];
    assign w_ram_idx          = ram_address[AW+1:2];
    assign w_unused_byte_bits = ^ram_address[1:0];

    // FIFO state
    logic [WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    // Write-side control decoded from the single core port
    logic w_wr_ram;
    logic w_push_req;
    logic w_clr;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;

    assign w_wr_ram   = Read_Write_ram_en && w_ram_hit;
    assign w_push_req = Read_Write_ram_en && w_mmio_hit && (w_off == 2'd1);
    assign w_clr      = Read_Write_ram_en && w_mmio_hit && (w_off == 2'd3);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = out_valid && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;

    assign out_valid = (r_count != '0);
    assign out_data  = r_fifo[r_rd_ptr];

    // Word RAM: synchronous write, contents deliberately not reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Commit RAM stores at the rising edge; reads see the old word until then.
    always_ff @(posedge CLOCK) begin
        if (w_wr_ram) begin
            r_mem[w_ram_idx] <= ram_w_data;
        end
    end

    // FIFO pointers, count, storage and sticky overflow (set beats clear).
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[PW'(i)] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= ram_w_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    logic [WIDTH-1:0] w_cycle;

`ifdef RAM_RESPONDER_CYCLE_CNT_EN
    logic [WIDTH-1:0] r_cycle;

    // Free-running cycle counter, wraps naturally at 2^WIDTH.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    logic [WIDTH-1:0] w_status;

    // STATUS layout: bit0 empty, bit1 full, bit2 overflow, bits[7:4] count.
    always_comb begin
        w_status      = '0;
        w_status[0]   = (r_count == '0);
        w_status[1]   = w_full;
        w_status[2]   = r_ovf;
        w_status[7:4] = 4'(r_count);
    end

    // Zero-latency read mux; write-only and unmapped locations read as 0.
    always_comb begin
        ram_r_data = '0;
        if (w_ram_hit) begin
            ram_r_data = r_mem[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_off)
                2'd0:    ram_r_data = w_cycle;
                2'd2:    ram_r_data = w_status;
                default: ram_r_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed self-checking bench for ram_responder with a
// scoreboard queue modelling the output FIFO contents.
module tb_ram_responder;
    localparam logic [31:0] A_CYCLE = 32'hFFFF_FF00;
    localparam logic [31:0] A_OUT   = 32'hFFFF_FF04;
    localparam logic [31:0] A_STAT  = 32'hFFFF_FF08;
    localparam logic [31:0] A_CLR   = 32'hFFFF_FF0C;

    logic        CLOCK             = 1'b0;
    logic        RESET             = 1'b0;
    logic [31:0] ram_address       = '0;
    logic [31:0] ram_w_data        = '0;
    logic        Read_Write_ram_en = 1'b0;
    logic [31:0] ram_r_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready         = 1'b0;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];

    ram_responder dut (
        .CLOCK             (CLOCK),
        .RESET             (RESET),
        .ram_address       (ram_address),
        .ram_w_data        (ram_w_data),
        .Read_Write_ram_en (Read_Write_ram_en),
        .ram_r_data        (ram_r_data),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_ready         (out_ready)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        Read_Write_ram_en = 1'b0;
        ram_address       = a;
        #1;
        check(tag, ram_r_data, exp);
    endtask

    // One clock cycle with the FIFO model: check head, then apply pop/push.
    task automatic step();
        bit push_req;
        bit pop_now;
        bit accept;
        #1;
        push_req = Read_Write_ram_en && (ram_address == A_OUT);
        pop_now  = out_ready && (sb.size() != 0);
        accept   = push_req && ((sb.size() < 4) || pop_now);
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) check("out_data", out_data, sb[0]);
        if (pop_now) sb.delete(0);
        if (accept) sb.push_back(ram_w_data);
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ram_address       = a;
        ram_w_data        = d;
        Read_Write_ram_en = 1'b1;
        step();
        Read_Write_ram_en = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL drain_timeout: observed %0d entries left expected 0", sb.size());
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rd(A_STAT, 32'h1, "rst_status");
        rd(A_CYCLE, 32'd0, "rst_cycle");
        #1 RESET = 1'b1;

        // Cycle counter after 10 edges
        repeat (10) tick();
`ifdef RAM_RESPONDER_CYCLE_CNT_EN
        rd(A_CYCLE, 32'd10, "cycle_after_10");
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        rd(A_CYCLE, 32'hFFFF_FFFF, "cycle_forced");
        release dut.r_cycle;
        tick();
        rd(A_CYCLE, 32'd0, "cycle_wrap");
`else
        rd(A_CYCLE, 32'd0, "cycle_disabled");
        tick();
        rd(A_CYCLE, 32'd0, "cycle_disabled_2");
`endif

        // RAM read/write
        wr(32'h0, 32'h1111_1111);
        wr(32'h10, 32'hCAFE_0001);
        ram_address       = 32'h10;
        ram_w_data        = 32'hDEAD_BEEF;
        Read_Write_ram_en = 1'b1;
        #1;
        check("same_cycle_old", ram_r_data, 32'hCAFE_0001);
        step();
        Read_Write_ram_en = 1'b0;
        rd(32'h10, 32'hDEAD_BEEF, "ram_rd_new");

        // Unmapped access
        rd(32'h2000, 32'd0, "unmapped_rd");
        ram_address       = 32'h2000;
        ram_w_data        = 32'h1234_5678;
        Read_Write_ram_en = 1'b1;
        #1;
        check("unmapped_rd_wr", ram_r_data, 32'd0);
        step();
        Read_Write_ram_en = 1'b0;
        rd(32'h0, 32'h1111_1111, "word0_intact");
        rd(A_OUT, 32'd0, "out_data_reads_0");

        // Fill FIFO, overflow, drain
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) wr(A_OUT, 32'(v));
        rd(A_STAT, 32'h42, "status_full");
        wr(A_OUT, 32'd5);
        rd(A_STAT, 32'h46, "status_ovf");
        drain();
        check("valid_after_drain", 32'(out_valid), 32'd0);
        rd(A_STAT, 32'h05, "status_empty_ovf");
        wr(A_CLR, 32'd0);
        rd(A_STAT, 32'h01, "status_cleared");

        // Push into full FIFO while head pops
        for (int v = 5; v <= 8; v++) wr(A_OUT, 32'(v));
        out_ready = 1'b1;
        wr(A_OUT, 32'd9);
        out_ready = 1'b0;
        rd(A_STAT, 32'h42, "status_push_pop_full");
        drain();

        // Asynchronous reset mid-operation with 3 entries
        for (int v = 0; v < 3; v++) wr(A_OUT, 32'hA1 + 32'(v));
        #2 RESET = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        sb.delete();
        rd(A_STAT, 32'h1, "async_rst_status");
        #1 RESET = 1'b1;
        tick();
        rd(A_STAT, 32'h1, "post_rst_status");
        wr(A_OUT, 32'h77);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
